shift_rows_stream: RTL and testbench

SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

---
 rtl/shift_rows_stream.sv | 100 ++++++++++
 tb/tb_shift_rows_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stream.sv
// AES ShiftRows / InvShiftRows on a streamed state, followed by a DEPTH-entry output FIFO.
// Optional accepted-beat counter on blk_count when SHIFT_ROWS_STREAM_CNT_EN is defined.
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_dec,
    input  logic [0:32*NB-1]  state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:32*NB-1]  new_state,
    output logic              out_dec,
    output logic [31:0]       blk_count
);

    localparam int W  = 32 * NB;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [0:W-1]  w_shifted;
    logic          w_push;
    logic          w_pop;

    logic [0:W-1]  r_mem_state [DEPTH];
    logic          r_mem_dec   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Source column for output byte (r, c); Rijndael uses larger row 2/3 offsets at NB=8.
    function automatic int src_col(input int r, input int c, input logic dec);
        int off;
        case (r)
            0:       off = 0;
            1:       off = 1;
            2:       off = (NB == 8) ? 3 : 2;
            default: off = (NB == 8) ? 4 : 3;
        endcase
        return dec ? ((c + NB - off) % NB) : ((c + off) % NB);
    endfunction

    always_comb begin
        w_shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                w_shifted[8*(4*c + r) +: 8] = state[8*(4*src_col(r, c, in_dec) + r) +: 8];
            end
        end
    end

    // rst forces in_ready low in the reset cycle itself; out_ready never reaches it.
    assign in_ready  = !rst && (r_count != DEPTH_C);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign new_state = out_valid ? r_mem_state[r_rd_ptr] : '0;
    assign out_dec   = out_valid ? r_mem_dec[r_rd_ptr]   : 1'b0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_state[r_wr_ptr] <= w_shifted;
            r_mem_dec[r_wr_ptr]   <= in_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SHIFT_ROWS_STREAM_CNT_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clk) begin
        if (rst)         r_blk_count <= '0;
        else if (w_push) r_blk_count <= r_blk_count + 32'd1;
    end

    assign blk_count = r_blk_count;
`else
    assign blk_count = '0;
`endif

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: queue-based reference model checked every cycle, plus literal vectors.
module tb_shift_rows_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic iv4, ir4, id4, ov4, or4, od4;
    logic [0:127] st4, ns4;
    logic [31:0]  bc4;
    logic iv8, ir8, id8, ov8, or8, od8;
    logic [0:255] st8, ns8;
    logic [31:0]  bc8;

    shift_rows_stream #(.NB(4), .DEPTH(2)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_dec(id4), .state(st4),
        .out_valid(ov4), .out_ready(or4), .new_state(ns4), .out_dec(od4), .blk_count(bc4));

    shift_rows_stream #(.NB(8), .DEPTH(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_dec(id8), .state(st8),
        .out_valid(ov8), .out_ready(or8), .new_state(ns8), .out_dec(od8), .blk_count(bc8));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // State as a 4 x nb byte matrix; each row rotated by its offset.
    function automatic logic [0:255] xform(input logic [0:255] s, input int nb, input logic dec);
        logic [7:0]   m [4][8];
        logic [0:255] o;
        int           offs [4];
        int           src;
        o = '0;
        offs[0] = 0; offs[1] = 1;
        if (nb == 8) begin offs[2] = 3; offs[3] = 4; end
        else         begin offs[2] = 2; offs[3] = 3; end
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[8*(4*c + r) +: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++) begin
                src = dec ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
                o[8*(4*c + r) +: 8] = m[r][src];
            end
        return o;
    endfunction

    typedef struct { logic [0:255] s; logic d; } beat_t;
    beat_t q4[$];
    beat_t q8[$];
    int    cnt4 = 0;
    int    cnt8 = 0;
    bit    started = 0;
    bit    p4, pp4, p8, pp8;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            q4.delete(); q8.delete();
            cnt4 = 0; cnt8 = 0;
            started = 1;
        end else begin
            p4  = iv4 && (q4.size() < 2);
            pp4 = (q4.size() > 0) && or4;
            p8  = iv8 && (q8.size() < 2);
            pp8 = (q8.size() > 0) && or8;
            if (pp4) void'(q4.pop_front());
            if (pp8) void'(q8.pop_front());
            if (p4) begin q4.push_back('{xform({st4, 128'h0}, 4, id4), id4}); cnt4++; end
            if (p8) begin q8.push_back('{xform(st8, 8, id8), id8}); cnt8++; end
        end
    end

    function automatic logic [31:0] exp_cnt(input int c);
`ifdef SHIFT_ROWS_STREAM_CNT_EN
        return 32'(c);
`else
        return 32'(c) & 32'd0;
`endif
    endfunction

    logic [0:255] h4, h8;
    initial forever begin
        @(negedge clk);
        if (started) begin
            h4 = (q4.size() > 0) ? q4[0].s : '0;
            h8 = (q8.size() > 0) ? q8[0].s : '0;
            chk("in_ready4",  ir4, !rst && (q4.size() < 2));
            chk("out_valid4", ov4, q4.size() > 0);
            chk("new_state4", ns4, h4[0:127]);
            chk("out_dec4",   od4, (q4.size() > 0) ? q4[0].d : 1'b0);
            chk("blk_count4", bc4, exp_cnt(cnt4));
            chk("in_ready8",  ir8, !rst && (q8.size() < 2));
            chk("out_valid8", ov8, q8.size() > 0);
            chk("new_state8", ns8, h8);
            chk("out_dec8",   od8, (q8.size() > 0) ? q8[0].d : 1'b0);
            chk("blk_count8", bc8, exp_cnt(cnt8));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [0:127] VA  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [0:127] VB  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [0:127] VC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] VCE = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [0:127] VCD = 128'h000d0a0704010e0b0805020f0c090603;

    logic [0:255] tmp, rnd, enc;
    logic [0:127] x1, x2, x3;

    initial begin
        rst = 1'b1;
        iv4 = 0; id4 = 0; st4 = '0; or4 = 1;
        iv8 = 0; id8 = 0; st8 = '0; or8 = 1;

        tmp = xform({VA, 128'h0}, 4, 1'b0); chk("model_enc_A", tmp[0:127], VB);
        tmp = xform({VC, 128'h0}, 4, 1'b0); chk("model_enc_C", tmp[0:127], VCE);
        tmp = xform({VC, 128'h0}, 4, 1'b1); chk("model_dec_C", tmp[0:127], VCD);

        repeat (2) cyc();
        rst = 1'b0;

        // FIPS-197 round vector, encrypt then decrypt
        iv4 = 1; id4 = 0; st4 = VA; cyc(); iv4 = 0;
        @(negedge clk);
        chk("lit_enc_A", ns4, VB); chk("lit_enc_A_dec", od4, 1'b0); chk("lit_enc_A_valid", ov4, 1'b1);
        cyc();
        iv4 = 1; id4 = 1; st4 = VB; cyc(); iv4 = 0;
        @(negedge clk);
        chk("lit_dec_B", ns4, VA); chk("lit_dec_B_dec", od4, 1'b1);
        cyc();

        // Counting pattern, back-to-back enc/dec
        iv4 = 1; id4 = 0; st4 = VC; cyc(); id4 = 1;
        @(negedge clk); chk("lit_enc_C", ns4, VCE);
        cyc(); iv4 = 0;
        @(negedge clk); chk("lit_dec_C", ns4, VCD);
        cyc();

        // Backpressure: fill, hold third beat, then drain in order
        x1 = 128'h11111111222222223333333344444444;
        x2 = 128'h0123456789abcdeffedcba9876543210;
        x3 = 128'hdeadbeefcafef00d0badc0de5a5aa5a5;
        or4 = 0; iv4 = 1; id4 = 0; st4 = x1; cyc();
        st4 = x2; cyc();
        st4 = x3; cyc(); cyc();
        @(negedge clk);
        tmp = xform({x1, 128'h0}, 4, 1'b0);
        chk("bp_full_ready", ir4, 1'b0); chk("bp_head_x1", ns4, tmp[0:127]);
        cyc(); or4 = 1; cyc();
        @(negedge clk);
        tmp = xform({x2, 128'h0}, 4, 1'b0);
        chk("bp_head_x2", ns4, tmp[0:127]); chk("bp_ready_again", ir4, 1'b1);
        cyc(); iv4 = 0;
        @(negedge clk);
        tmp = xform({x3, 128'h0}, 4, 1'b0);
        chk("bp_head_x3", ns4, tmp[0:127]);
        cyc();
        @(negedge clk); chk("bp_drained", ov4, 1'b0);
        cyc();

        // Reset with two beats buffered and push/pop requested
        or4 = 0; iv4 = 1; st4 = x1; cyc();
        st4 = x2; cyc();
        rst = 1; or4 = 1;
        @(negedge clk); chk("rst_cycle_ready", ir4, 1'b0);
        cyc(); rst = 0; iv4 = 0;
        @(negedge clk);
        chk("rst_out_valid", ov4, 1'b0); chk("rst_in_ready", ir4, 1'b1);
        chk("rst_blk_count", bc4, 32'd0); chk("rst_new_state", ns4, 128'h0);
        repeat (4) cyc();

        // NB=8 round trip of a random state
        rnd = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        enc = xform(rnd, 8, 1'b0);
        iv8 = 1; id8 = 0; st8 = rnd; cyc();
        id8 = 1; st8 = enc;
        @(negedge clk); chk("nb8_enc", ns8, enc);
        cyc(); iv8 = 0;
        @(negedge clk);
        chk("nb8_roundtrip", ns8, rnd); chk("nb8_out_dec", od8, 1'b1);
        chk("nb8_blk_count", bc8, exp_cnt(2));
        cyc();

        // Random traffic on NB=4 with pointer wrap and mixed push/pop
        for (int i = 0; i < 80; i++) begin
            iv4 = 1'($urandom_range(0, 1));
            or4 = 1'($urandom_range(0, 1));
            id4 = 1'($urandom_range(0, 1));
            st4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc();
        end
        iv4 = 0; or4 = 1;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
